shift_right_sequencer: RTL and testbench
========================================

// Module: shift_right_sequencer
// PURPOSE
//   Multi-cycle controller around the 8-bit shift_right_unit: accepts data, op and shift count,
//   then steps the unit once per clock until the count is exhausted. Returns result and last
//   shifted-out bit. Carry is chained between steps, so op RRC is a 9-bit rotate through carry.
//   Sits between the ALU operand registers and the result bus; one operation in flight at a time.
// PARAMETERS
//   DATA_W  8  datapath width; fixed at 8, which is the width of the shift unit
//   CNT_W   4  count width; shift amounts 0..15 are legal
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous, active-high reset
//   start      in   1       request; accepted only when busy==0
//   op         in   2       00 LSR, 01 ROR, 10 RRC, 11 ASR (maps to the unit's {sel1,sel0})
//   data_in    in   DATA_W  operand, captured on the accepted start
//   cin        in   1       initial carry, captured on the accepted start
//   count      in   CNT_W   number of single-bit steps, captured on the accepted start
//   busy       out  1       high while in SHIFT
//   done       out  1       one-cycle pulse when result is valid
//   result     out  DATA_W  shifted value; holds until the next accepted start or reset
//   carry_out  out  1       last bit shifted out (LSB before final step); cin if count==0
//   zero       out  1       only with SRS_ZERO_FLAG_EN
// BEHAVIOUR
//   - Reset: state=IDLE; busy, done, result, carry_out (and zero) all 0.
//   - FSM IDLE -> SHIFT on start; SHIFT -> SHIFT while rem!=0; SHIFT -> DONE when rem==0.
//     DONE -> IDLE, or DONE -> SHIFT on start.
//   - Accept (IDLE or DONE, start==1): data_q<=data_in, c_q<=cin, rem<=count, op_q<=op.
//     Op is frozen for the whole operation.
//   - SHIFT with rem!=0: data_q<=unit.f, with the unit fed x=data_q, cin=c_q, sel=op_q.
//     c_q<=data_q[0] for every op, independent of the unit's cout. rem<=rem-1.
//   - Latency: start sampled at edge T; done is high in the cycle after edge T+count+1.
//     count==0 gives done after T+1 with result=data_in and carry_out=cin.
//   - busy=1 exactly in SHIFT. done=1 exactly in DONE. result/carry_out are driven from
//     data_q/c_q and are valid whenever done==1 or IDLE after a completed op.
//   - start while busy==1 is ignored; no queueing and no error flag.
//   - start in the DONE cycle is accepted (back-to-back); done still pulses for that cycle.
//   - Reset mid-operation aborts immediately to the reset values; no done pulse.
//   - count>=8: steps continue normally. LSR reaches 0x00; ASR saturates to 0x00 or 0xFF;
//     ROR has period 8; RRC has period 9.
// CONFIGURATION
//   SRS_ZERO_FLAG_EN defined: adds output zero = (result==8'h00), registered alongside
//     result and reset to 0.
//   SRS_ZERO_FLAG_EN undefined: port zero and its logic are absent; all else identical.
// STRUCTURE
//   - Package shift_seq_pkg: localparams OP_LSR=2'b00, OP_ROR=2'b01, OP_RRC=2'b10,
//     OP_ASR=2'b11; state encodings S_IDLE, S_SHIFT, S_DONE; DATA_W and CNT_W defaults.
//   - Sub-module: one instance of the existing shift_right_unit (the datapath). FSM, counter,
//     data_q and c_q live in this module. The unit's cout is left unconnected.
// TESTING
//   1. rst=1 for 2 cycles -> busy=0, done=0, result=8'h00, carry_out=0; start held during
//      rst has no effect.
//   2. LSR data_in=8'h96, count=3, cin=0 -> done after T+4, result=8'h12, carry_out=1,
//      busy high for 4 cycles.
//   3. ROR data_in=8'h81, count=1 -> result=8'hC0, carry_out=1.
//      Repeat with count=8 -> result=8'h81, carry_out=1.
//   4. RRC data_in=8'h01, cin=0, count=2 -> result=8'h80, carry_out=0.
//      ASR data_in=8'h80, count=4 -> result=8'hF8, carry_out=0.
//   5. count=0, data_in=8'h5A, cin=1 -> done after T+1, result=8'h5A, carry_out=1.
//      Second start while busy -> ignored; first op's result unchanged.
//   6. rst pulsed mid-op (LSR count=10) -> next cycle all outputs 0, no done pulse.
//      Back-to-back start in DONE -> accepted. With SRS_ZERO_FLAG_EN: LSR 8'h01 count=1
//      -> zero=1.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared op codes, FSM state encoding and default widths for the shift-right sequencer.
package shift_seq_pkg;

    localparam int SEQ_DATA_W = 8;
    localparam int SEQ_CNT_W  = 4;

    localparam logic [1:0] OP_LSR = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_RRC = 2'b10;
    localparam logic [1:0] OP_ASR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_right_unit.sv
// Combinational single-step 8-bit right shifter: LSR, ROR, RRC (through carry), ASR.
// Zero latency; no flow control, output follows inputs.
module shift_right_unit
    import shift_seq_pkg::*;
(
    input  logic [7:0] x,
    input  logic       cin,
    input  logic       sel1,
    input  logic       sel0,
    output logic [7:0] f,
    output logic       cout
);

    logic msb;

    always_comb begin
        msb = 1'b0;
        unique case ({sel1, sel0})
            OP_LSR:  msb = 1'b0;
            OP_ROR:  msb = x[0];
            OP_RRC:  msb = cin;
            default: msb = x[7];
        endcase
    end

    assign f    = {msb, x[7:1]};
    assign cout = x[0];

endmodule

// File: rtl/shift_right_sequencer.sv
// Multi-cycle right-shift controller: one unit step per clock, done pulses count+1 cycles after start.
// Starts while busy are dropped; optional zero flag enabled by defining SRS_ZERO_FLAG_EN.
module shift_right_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DATA_W = SEQ_DATA_W,
    parameter int CNT_W  = SEQ_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] data_in,
    input  logic              cin,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry_out
`ifdef SRS_ZERO_FLAG_EN
    ,
    output logic              zero
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                c_q, c_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   unit_f;

    shift_right_unit u_unit (
        .x    (data_q),
        .cin  (c_q),
        .sel1 (op_q[1]),
        .sel0 (op_q[0]),
        .f    (unit_f),
        .cout ()
    );

`ifdef SRS_ZERO_FLAG_EN
    logic zero_q, zero_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        c_d     = c_q;
        rem_d   = rem_q;
        op_d    = op_q;
`ifdef SRS_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    data_d  = data_in;
                    c_d     = cin;
                    rem_d   = count;
                    op_d    = op;
`ifdef SRS_ZERO_FLAG_EN
                    zero_d  = (data_in == '0);
`endif
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (rem_q != '0) begin
                    // Carry chain takes the outgoing LSB regardless of op.
                    data_d = unit_f;
                    c_d    = data_q[0];
                    rem_d  = rem_q - CNT_ONE;
`ifdef SRS_ZERO_FLAG_EN
                    zero_d = (unit_f == '0);
`endif
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            c_q     <= 1'b0;
            rem_q   <= '0;
            op_q    <= OP_LSR;
`ifdef SRS_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            c_q     <= c_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
`ifdef SRS_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign busy      = (state_q == S_SHIFT);
    assign done      = (state_q == S_DONE);
    assign result    = data_q;
    assign carry_out = c_q;
`ifdef SRS_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_shift_right_sequencer.sv
// Table-driven bench with an expected-result queue for shift_right_sequencer.
module tb_shift_right_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] op;
    logic [7:0] data_in;
    logic       cin;
    logic [3:0] count;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
`ifdef SRS_ZERO_FLAG_EN
    logic       zero;
`endif

    shift_right_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .data_in   (data_in),
        .cin       (cin),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
`ifdef SRS_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] din;
        logic       cin;
        logic [3:0] cnt;
        logic [7:0] res;
        logic       cy;
        logic       poke;
    } vec_t;

    typedef struct {
        logic [7:0] res;
        logic       cy;
        int         lat;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] o, input logic [7:0] d, input logic c, input logic [3:0] n);
        start   = 1'b1;
        op      = o;
        data_in = d;
        cin     = c;
        count   = n;
    endtask

    task automatic push(input logic [7:0] r, input logic c, input logic [3:0] n);
        exp_t e;
        e.res = r;
        e.cy  = c;
        e.lat = int'(n) + 1;
        sb.push_back(e);
    endtask

    // pre: cycles already elapsed (and seen busy) since the accepting edge
    task automatic wait_done(input int pre);
        exp_t e;
        int   n;
        int   nb;
        bit   seen;
        n = pre;
        nb = pre;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1'b1;
            else if (busy) nb++;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=no_done required=done");
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_empty actual=done required=no_done");
        end else begin
            e = sb.pop_front();
            check("latency", n, e.lat);
            check("busy_cycles", nb, e.lat - 1);
            check("busy_in_done", busy, 1'b0);
            check("result", result, e.res);
            check("carry_out", carry_out, e.cy);
`ifdef SRS_ZERO_FLAG_EN
            check("zero", zero, (e.res == 8'h00));
`endif
        end
    endtask

    task automatic do_op(input vec_t v);
        @(negedge clk);
        drive(v.op, v.din, v.cin, v.cnt);
        @(posedge clk);
        push(v.res, v.cy, v.cnt);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        if (v.poke) begin
            drive(2'b00, 8'hFF, 1'b0, 4'd0);
            @(posedge clk);
            #1;
            start = 1'b0;
            check("busy_ignores_start", busy, 1'b1);
            wait_done(1);
        end else begin
            wait_done(0);
        end
        @(posedge clk);
        #1;
        check("idle_done_low", done, 1'b0);
        check("idle_result_hold", result, v.res);
    endtask

    initial begin
        int nd;
        vecs[0]  = '{2'b00, 8'h96, 1'b0, 4'd3,  8'h12, 1'b1, 1'b0};
        vecs[1]  = '{2'b01, 8'h81, 1'b0, 4'd1,  8'hC0, 1'b1, 1'b0};
        vecs[2]  = '{2'b01, 8'h81, 1'b0, 4'd8,  8'h81, 1'b1, 1'b0};
        vecs[3]  = '{2'b10, 8'h01, 1'b0, 4'd2,  8'h80, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 8'h80, 1'b0, 4'd4,  8'hF8, 1'b0, 1'b0};
        vecs[5]  = '{2'b00, 8'h5A, 1'b1, 4'd0,  8'h5A, 1'b1, 1'b0};
        vecs[6]  = '{2'b00, 8'h96, 1'b0, 4'd3,  8'h12, 1'b1, 1'b1};
        vecs[7]  = '{2'b00, 8'hFF, 1'b1, 4'd10, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 8'h80, 1'b0, 4'd15, 8'hFF, 1'b1, 1'b0};
        vecs[9]  = '{2'b10, 8'hA5, 1'b1, 4'd9,  8'hA5, 1'b1, 1'b0};
        vecs[10] = '{2'b01, 8'h01, 1'b0, 4'd15, 8'h02, 1'b0, 1'b0};
        vecs[11] = '{2'b00, 8'h01, 1'b0, 4'd1,  8'h00, 1'b1, 1'b0};

        // Reset with start held high
        rst = 1'b1;
        drive(2'b01, 8'hFF, 1'b1, 4'd2);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_result", result, 8'h00);
        check("rst_carry", carry_out, 1'b0);
`ifdef SRS_ZERO_FLAG_EN
        check("rst_zero", zero, 1'b0);
`endif
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_busy", busy, 1'b0);

        for (int i = 0; i < 12; i++) do_op(vecs[i]);

        // Back-to-back: start issued during the DONE cycle
        @(negedge clk);
        drive(2'b01, 8'h81, 1'b0, 4'd1);
        @(posedge clk);
        push(8'hC0, 1'b1, 4'd1);
        #1;
        start = 1'b0;
        wait_done(0);
        drive(2'b11, 8'h80, 1'b0, 4'd4);
        check("b2b_done_pulse", done, 1'b1);
        @(posedge clk);
        push(8'hF8, 1'b0, 4'd4);
        #1;
        start = 1'b0;
        check("b2b_accepted", busy, 1'b1);
        wait_done(0);

        // Reset mid-operation
        @(negedge clk);
        drive(2'b00, 8'hFF, 1'b1, 4'd10);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, 8'h00);
        check("abort_carry", carry_out, 1'b0);
`ifdef SRS_ZERO_FLAG_EN
        check("abort_zero", zero, 1'b0);
`endif
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) nd++;
        end
        check("abort_no_done", nd, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
